// File: rtl/sram_bist_pkg.sv
// Shared types and helpers for the SRAM built-in self-test sequencer.
//   state_e   : sequencer states (idle, write sweep, read sweep, drain, done)
//   DefAw/DefDw/DefSeed : default RAM geometry and pattern seed
//   pat()     : test pattern, (addr ^ seed), optionally inverted
package sram_bist_pkg;

  localparam int unsigned DefAw   = 5;
  localparam int unsigned DefDw   = 4;
  localparam logic [3:0]  DefSeed = 4'hA;

  // Wide working width for pat(); callers truncate to their data width.
  localparam int unsigned PatW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  function automatic logic [PatW-1:0] pat(input logic [PatW-1:0] addr,
                                          input logic [PatW-1:0] seed,
                                          input logic            inv);
    logic [PatW-1:0] p;
    p = addr ^ seed;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/sram_bist_dly.sv
// RD_LAT-stage pipeline carrying {valid, addr, expected} alongside the SRAM read
// latency so each entry emerges in the same cycle as its read data.
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset (clears all stages)
//   valid_i/addr_i/exp_i : entry pushed every cycle
//   valid_o/addr_o/exp_o : entry that was pushed RD_LAT cycles earlier
module sram_bist_dly #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] exp_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] exp_o
);

  localparam int unsigned EW = 1 + AW + DW;

  logic [EW-1:0] stage_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= {valid_i, addr_i, exp_i};
      for (int i = 1; i < int'(RD_LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign {valid_o, addr_o, exp_o} = stage_q[RD_LAT-1];

endmodule

// File: rtl/sram_bist.sv
// SRAM built-in self-test sequencer. Writes pattern(addr) to every location,
// reads every location back and compares, reporting pass/fail and the first
// failing address/data.
// Ports:
//   clk, rst (sync, active-high), start (one-cycle request)
//   busy, done, pass, fail_addr, fail_data : status to the system controller
//   ram_addr, ram_din, ram_we (registered), ram_dout : SRAM connection
// Build option: SRAM_BIST_INVERT_PASS_EN adds a second write/read pass with the
// inverted pattern after a clean first pass.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned   AW     = DefAw,
  parameter int unsigned   DW     = DefDw,
  parameter logic [DW-1:0] SEED   = DW'(DefSeed),
  parameter int unsigned   RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] DrainLast = 2'(RD_LAT - 1);

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input logic inv);
    return DW'(pat(PatW'(a), PatW'(SEED), inv));
  endfunction

  state_e        state_q;
  logic          busy_q, done_q, pass_q, ram_we_q;
  logic [AW-1:0] fail_addr_q, ram_addr_q;
  logic [DW-1:0] fail_data_q, ram_din_q;
  logic [1:0]    drain_cnt_q;

  logic          inv_sel;  // selects the inverted pattern
  logic          rerun;    // clean first pass should be followed by a second one

`ifdef SRAM_BIST_INVERT_PASS_EN
  logic pass_idx_q;
  assign inv_sel = pass_idx_q;
  assign rerun   = ~pass_idx_q;
`else
  assign inv_sel = 1'b0;
  assign rerun   = 1'b0;
`endif

  logic [AW-1:0] next_addr;
  logic          last_addr;
  assign next_addr = ram_addr_q + AW'(1);
  assign last_addr = (ram_addr_q == '1);

  logic          dly_valid;
  logic [AW-1:0] dly_addr;
  logic [DW-1:0] dly_exp;

  sram_bist_dly #(
    .RD_LAT(RD_LAT),
    .AW    (AW),
    .DW    (DW)
  ) u_dly (
    .clk_i  (clk),
    .rst_i  (rst),
    .valid_i(state_q == StRead),
    .addr_i (ram_addr_q),
    .exp_i  (exp_data(ram_addr_q, inv_sel)),
    .valid_o(dly_valid),
    .addr_o (dly_addr),
    .exp_o  (dly_exp)
  );

  // Only compare while reads are outstanding; stale entries after an abort are ignored.
  logic mismatch;
  assign mismatch = dly_valid && (ram_dout != dly_exp) &&
                    ((state_q == StRead) || (state_q == StDrain));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
      drain_cnt_q <= '0;
`ifdef SRAM_BIST_INVERT_PASS_EN
      pass_idx_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StWrite;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_din_q   <= exp_data('0, 1'b0);
`ifdef SRAM_BIST_INVERT_PASS_EN
            pass_idx_q  <= 1'b0;
`endif
          end
        end
        StWrite: begin
          if (last_addr) begin
            state_q    <= StRead;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
          end else begin
            ram_addr_q <= next_addr;
            ram_din_q  <= exp_data(next_addr, inv_sel);
          end
        end
        StRead, StDrain: begin
          if (mismatch) begin
            // First mismatch ends the test; in-flight reads are abandoned.
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_addr_q <= dly_addr;
            fail_data_q <= ram_dout;
            ram_addr_q  <= '0;
          end else if (state_q == StRead) begin
            if (last_addr) begin
              state_q     <= StDrain;
              ram_addr_q  <= '0;
              drain_cnt_q <= '0;
            end else begin
              ram_addr_q <= next_addr;
            end
          end else if (drain_cnt_q == DrainLast) begin
            if (rerun) begin
              state_q    <= StWrite;
              ram_we_q   <= 1'b1;
              ram_addr_q <= '0;
              ram_din_q  <= exp_data('0, 1'b1);
`ifdef SRAM_BIST_INVERT_PASS_EN
              pass_idx_q <= 1'b1;
`endif
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: two instances (read latency 1 and 3), each with its own
// SRAM model; expected results are queued at start and checked when done rises.
module tb_sram_bist;

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 4;
  localparam logic [3:0]  SEED = 4'hA;

`ifdef SRAM_BIST_INVERT_PASS_EN
  localparam int unsigned NPass = 2;
`else
  localparam int unsigned NPass = 1;
`endif

  typedef struct {
    int unsigned idx;
    logic        pass;
    logic [4:0]  fa;
    logic [3:0]  fd;
    int unsigned cyc;
    int unsigned writes;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst;
  logic [1:0]    start;
  logic          fault     [2];
  logic          busy      [2];
  logic          done      [2];
  logic          pass      [2];
  logic [AW-1:0] fail_addr [2];
  logic [DW-1:0] fail_data [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_din   [2];
  logic          ram_we    [2];
  logic [DW-1:0] ram_dout  [2];

  int unsigned edge_cnt = 0;
  int unsigned t0       [2];
  int unsigned wr_cnt   [2];
  int unsigned post_bad [2];
  int unsigned checks   = 0;
  int unsigned fails    = 0;
  exp_t        exp_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Lat = (g == 0) ? 1 : 3;

    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] rd_pipe [Lat];
    logic          done_d = 1'b0;
    logic          busy_d = 1'b0;

    sram_bist #(
      .AW    (AW),
      .DW    (DW),
      .SEED  (SEED),
      .RD_LAT(Lat)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .pass     (pass[g]),
      .fail_addr(fail_addr[g]),
      .fail_data(fail_data[g]),
      .ram_addr (ram_addr[g]),
      .ram_din  (ram_din[g]),
      .ram_we   (ram_we[g]),
      .ram_dout (ram_dout[g])
    );

    // SRAM model; the fault makes bit0 of location 7 stuck at 0.
    always @(posedge clk) begin
      if (ram_we[g]) begin
        mem[ram_addr[g]] <= (fault[g] && ram_addr[g] == 5'd7) ? (ram_din[g] & 4'hE)
                                                             : ram_din[g];
      end
      rd_pipe[0] <= mem[ram_addr[g]];
      for (int i = 1; i < int'(Lat); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout[g] = rd_pipe[Lat-1];

    // Write checker: writes of a run must sweep 0..31 with the expected pattern.
    always @(negedge clk) begin : wmon
      logic [3:0] ed;
      if (busy[g] && !busy_d) wr_cnt[g] = 0;
      busy_d = busy[g];
      if (ram_we[g]) begin
        ed = wr_cnt[g][3:0] ^ SEED;
        if (wr_cnt[g] >= 32) ed = ~ed;
        check("wr_addr", 32'(ram_addr[g]), wr_cnt[g] % 32);
        check("wr_din", 32'(ram_din[g]), 32'(ed));
        wr_cnt[g]++;
      end
    end

    // Result monitor: pops the scoreboard whenever done rises.
    always @(negedge clk) begin : mon
      exp_t e;
      if (done[g] && !done_d) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done inst %0d: done=1, required no result", g);
        end else begin
          e = exp_q.pop_front();
          check("done_inst", g, e.idx);
          check("pass", 32'(pass[g]), 32'(e.pass));
          check("fail_addr", 32'(fail_addr[g]), 32'(e.fa));
          check("fail_data", 32'(fail_data[g]), 32'(e.fd));
          check("done_cycle", edge_cnt - t0[g], e.cyc);
          check("write_count", wr_cnt[g], e.writes);
          check("idle_after_done", {busy[g], ram_we[g], ram_addr[g]}, 32'd0);
        end
      end
      if (done[g] && (ram_we[g] || ram_addr[g] != '0)) post_bad[g]++;
      done_d = done[g];
    end
  end

  function automatic exp_t mk(input int unsigned idx, input logic p, input logic [4:0] fa,
                              input logic [3:0] fd, input int unsigned cyc,
                              input int unsigned writes);
    exp_t e;
    e.idx = idx; e.pass = p; e.fa = fa; e.fd = fd; e.cyc = cyc; e.writes = writes;
    return e;
  endfunction

  function automatic int unsigned ok_cyc(input int unsigned lat);
    return 1 + NPass * (64 + lat);
  endfunction

  task automatic kick(input int g);
    @(negedge clk);
    t0[g]    = edge_cnt;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    while (!done[g] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done[g]) begin
      checks++;
      fails++;
      $display("FAIL done_timeout inst %0d: done=0, required 1", g);
    end
    @(negedge clk);
  endtask

  initial begin
    int          n;
    int unsigned w;
    rst      = 2'b11;
    start    = 2'b00;
    fault[0] = 1'b0;
    fault[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("reset_state", {busy[g], done[g], pass[g], fail_addr[g], fail_data[g],
                            ram_addr[g], ram_din[g], ram_we[g]}, 32'd0);
    end
    rst = 2'b00;

    // Fault-free, latency 1
    exp_q.push_back(mk(0, 1'b1, 5'd0, 4'h0, ok_cyc(1), 32 * NPass));
    kick(0);
    wait_done(0);

    // Restart after a pass clears done/pass in the next cycle
    exp_q.push_back(mk(0, 1'b1, 5'd0, 4'h0, ok_cyc(1), 32 * NPass));
    kick(0);
    check("restart_clears", {done[0], pass[0], busy[0]}, 32'b001);
    wait_done(0);

    // start during WRITE is ignored
    exp_q.push_back(mk(0, 1'b1, 5'd0, 4'h0, ok_cyc(1), 32 * NPass));
    kick(0);
    while (edge_cnt < t0[0] + 19) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    // Stuck bit at location 7: write D, read back C
    fault[0] = 1'b1;
    exp_q.push_back(mk(0, 1'b0, 5'd7, 4'hC, 41 + 1, 32));
    kick(0);
    wait_done(0);
    fault[0] = 1'b0;

    // Reset in the middle of WRITE
    kick(0);
    n = 0;
    while (ram_addr[0] != 5'd10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_addr10", 32'(ram_addr[0]), 32'd10);
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {busy[0], done[0], pass[0], fail_addr[0], fail_data[0],
                              ram_addr[0], ram_din[0], ram_we[0]}, 32'd0);
    rst[0] = 1'b0;
    w = wr_cnt[0];
    repeat (5) @(negedge clk);
    check("no_write_after_rst", wr_cnt[0], w);
    exp_q.push_back(mk(0, 1'b1, 5'd0, 4'h0, ok_cyc(1), 32 * NPass));
    kick(0);
    wait_done(0);

    // Latency 3: fault-free, then stuck bit
    exp_q.push_back(mk(1, 1'b1, 5'd0, 4'h0, ok_cyc(3), 32 * NPass));
    kick(1);
    wait_done(1);
    fault[1] = 1'b1;
    exp_q.push_back(mk(1, 1'b0, 5'd7, 4'hC, 41 + 3, 32));
    kick(1);
    wait_done(1);

    repeat (5) @(negedge clk);
    check("post_done_activity_0", post_bad[0], 32'd0);
    check("post_done_activity_1", post_bad[1], 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
